// File: rtl/result_mem_arbiter.sv
// Shares one result-memory port between a row producer and two readers (A/B); writes win while the frame fills.
// Write ack and read grant are same-cycle; read data is valid one cycle after grant. Ineligible reads and writes in FULL stall.
module result_mem_arbiter #(
    parameter int element_width                   = 32,
    parameter int no_of_units                     = 8,
    parameter int number_of_equations_per_cluster = 9,
    parameter int rows = (number_of_equations_per_cluster + no_of_units - 1) / no_of_units
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wr_req,
    input  logic [element_width*no_of_units-1:0] wr_data,
    output logic                                 wr_ack,
    input  logic                                 rd_req_a,
    input  logic                                 rd_req_b,
    input  logic [31:0]                          rd_addr_a,
    input  logic [31:0]                          rd_addr_b,
    output logic                                 rd_gnt_a,
    output logic                                 rd_gnt_b,
    output logic                                 rd_valid_a,
    output logic                                 rd_valid_b,
    output logic [element_width*no_of_units-1:0] rd_data_a,
    output logic [element_width*no_of_units-1:0] rd_data_b,
    output logic                                 rd_err,
    output logic                                 frame_full,
    input  logic                                 frame_release,
    output logic [31:0]                          mem_address,
    output logic                                 mem_write_enable,
    output logic [element_width*no_of_units-1:0] mem_input_data,
    input  logic [element_width*no_of_units-1:0] mem_output
);

    localparam int          W      = element_width * no_of_units;
    localparam logic [31:0] ROWS_W = 32'(rows);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] wr_count;
    logic        rr_b;
    logic        wr_acc;
    logic        elig_a;
    logic        elig_b;
    logic        gnt_a;
    logic        gnt_b;
    logic        oor_a;
    logic        oor_b;

    // Out-of-range addresses are granted immediately so the requester gets an error instead of a hang.
    assign oor_a  = (rd_addr_a >= ROWS_W);
    assign oor_b  = (rd_addr_b >= ROWS_W);
    assign elig_a = rd_req_a && ((state == FULL) || (rd_addr_a < wr_count) || oor_a);
    assign elig_b = rd_req_b && ((state == FULL) || (rd_addr_b < wr_count) || oor_b);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (wr_acc && (wr_count == ROWS_W - 32'd1)) state_nxt = FULL;
            FULL: if (frame_release) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        wr_acc           = 1'b0;
        gnt_a            = 1'b0;
        gnt_b            = 1'b0;
        mem_address      = 32'd0;
        mem_write_enable = 1'b0;
        mem_input_data   = '0;
        if (rst_n) begin
            if ((state == FILL) && wr_req) begin
                wr_acc           = 1'b1;
                mem_write_enable = 1'b1;
                mem_address      = wr_count;
                mem_input_data   = wr_data;
            end else if (elig_a && (!elig_b || !rr_b)) begin
                gnt_a       = 1'b1;
                mem_address = rd_addr_a;
            end else if (elig_b) begin
                gnt_b       = 1'b1;
                mem_address = rd_addr_b;
            end
        end
    end

    assign wr_ack     = wr_acc;
    assign rd_gnt_a   = gnt_a;
    assign rd_gnt_b   = gnt_b;
    assign frame_full = (state == FULL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_count <= 32'd0;
        end else if ((state == FULL) && frame_release) begin
            wr_count <= 32'd0;
        end else if (wr_acc) begin
            wr_count <= wr_count + 32'd1;
        end
    end

    // rr_b=1 gives B priority on the next tie; it always points away from the last granted reader.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_b <= 1'b0;
        end else if (gnt_a) begin
            rr_b <= 1'b1;
        end else if (gnt_b) begin
            rr_b <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_a <= 1'b0;
            rd_valid_b <= 1'b0;
            rd_err     <= 1'b0;
            rd_data_a  <= '0;
            rd_data_b  <= '0;
        end else begin
            rd_valid_a <= gnt_a;
            rd_valid_b <= gnt_b;
            rd_err     <= (gnt_a && oor_a) || (gnt_b && oor_b);
            if (gnt_a) rd_data_a <= oor_a ? {W{1'b0}} : mem_output;
            if (gnt_b) rd_data_b <= oor_b ? {W{1'b0}} : mem_output;
        end
    end

    a_one_grant: assert property (@(posedge clk) disable iff (!rst_n) !(gnt_a && gnt_b));
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) wr_count <= ROWS_W);

endmodule

// File: tb/tb_result_mem_arbiter.sv
// Directed bench for result_mem_arbiter with a small behavioural result memory.
module tb_result_mem_arbiter;

    localparam int W = 256;
    localparam logic [W-1:0] R0   = {8{32'h11111111}};
    localparam logic [W-1:0] R1   = {8{32'h22222222}};
    localparam logic [W-1:0] R2   = {8{32'h33333333}};
    localparam logic [W-1:0] R3   = {8{32'h44444444}};
    localparam logic [W-1:0] JUNK = {8{32'hDEADBEEF}};

    logic         clk;
    logic         rst_n;
    logic         wr_req;
    logic [W-1:0] wr_data;
    logic         wr_ack;
    logic         rd_req_a;
    logic         rd_req_b;
    logic [31:0]  rd_addr_a;
    logic [31:0]  rd_addr_b;
    logic         rd_gnt_a;
    logic         rd_gnt_b;
    logic         rd_valid_a;
    logic         rd_valid_b;
    logic [W-1:0] rd_data_a;
    logic [W-1:0] rd_data_b;
    logic         rd_err;
    logic         frame_full;
    logic         frame_release;
    logic [31:0]  mem_address;
    logic         mem_write_enable;
    logic [W-1:0] mem_input_data;
    logic [W-1:0] mem_output;

    logic [W-1:0] mem [0:3];
    int n_cmp;
    int n_err;

    result_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req_a(rd_req_a), .rd_req_b(rd_req_b),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_gnt_a(rd_gnt_a), .rd_gnt_b(rd_gnt_b),
        .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rd_err(rd_err), .frame_full(frame_full), .frame_release(frame_release),
        .mem_address(mem_address), .mem_write_enable(mem_write_enable),
        .mem_input_data(mem_input_data), .mem_output(mem_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_enable && mem_address < 32'd4) mem[mem_address[1:0]] <= mem_input_data;
    end

    always_comb begin
        mem_output = JUNK;
        if (mem_address < 32'd4) mem_output = mem[mem_address[1:0]];
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        rst_n = 1'b0; wr_req = 1'b1; wr_data = R0;
        rd_req_a = 1'b0; rd_req_b = 1'b0; rd_addr_a = 32'd0; rd_addr_b = 32'd0;
        frame_release = 1'b0;

        // Reset holds off acks and clears registered outputs
        #1;
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_mem_we", mem_write_enable, 0);
        tick(); tick();
        chk("rst_frame_full", frame_full, 0);
        chk("rst_valid_a", rd_valid_a, 0);
        chk("rst_valid_b", rd_valid_b, 0);
        chk("rst_err", rd_err, 0);
        chk("rst_data_a", rd_data_a, 0);
        chk("rst_data_b", rd_data_b, 0);
        wr_req = 1'b0; rst_n = 1'b1;
        #1;
        chk("idle_we", mem_write_enable, 0);
        chk("idle_addr", mem_address, 0);
        tick();

        // Fill frame, with an early read of row 1 stalling until it is written
        wr_req = 1'b1; wr_data = R0;
        #1;
        chk("fill0_ack", wr_ack, 1);
        chk("fill0_we", mem_write_enable, 1);
        chk("fill0_addr", mem_address, 0);
        chk("fill0_data", mem_input_data, R0);
        tick();
        wr_data = R1; rd_req_a = 1'b1; rd_addr_a = 32'd1;
        #1;
        chk("fill1_ack", wr_ack, 1);
        chk("fill1_addr", mem_address, 1);
        chk("early_gnt_a", rd_gnt_a, 0);
        chk("fill1_full", frame_full, 0);
        tick();
        #1;
        chk("full_flag", frame_full, 1);
        chk("full_no_ack", wr_ack, 0);
        chk("early_gnt_a_now", rd_gnt_a, 1);
        chk("early_addr", mem_address, 1);
        chk("early_we", mem_write_enable, 0);
        tick();
        rd_req_a = 1'b0; wr_req = 1'b0;
        #1;
        chk("early_valid_a", rd_valid_a, 1);
        chk("early_data_a", rd_data_a, R1);
        chk("early_err", rd_err, 0);

        // Out-of-range read from B
        rd_req_b = 1'b1; rd_addr_b = 32'd5;
        #1;
        chk("oor_gnt_b", rd_gnt_b, 1);
        chk("oor_addr", mem_address, 5);
        tick();
        rd_req_b = 1'b0;
        #1;
        chk("oor_valid_b", rd_valid_b, 1);
        chk("oor_err", rd_err, 1);
        chk("oor_data_b", rd_data_b, 0);
        chk("oor_valid_a_low", rd_valid_a, 0);
        chk("hold_data_a", rd_data_a, R1);

        // Contention: pointer is back at A, expect A,B,A,B
        rd_req_a = 1'b1; rd_addr_a = 32'd0; rd_req_b = 1'b1; rd_addr_b = 32'd1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr%0d_gnt_a", i), rd_gnt_a, (i % 2) == 0);
            chk($sformatf("rr%0d_gnt_b", i), rd_gnt_b, (i % 2) == 1);
            tick();
            chk($sformatf("rr%0d_valid_a", i), rd_valid_a, (i % 2) == 0);
            chk($sformatf("rr%0d_valid_b", i), rd_valid_b, (i % 2) == 1);
            if (i % 2 == 0) chk($sformatf("rr%0d_data_a", i), rd_data_a, R0);
            else            chk($sformatf("rr%0d_data_b", i), rd_data_b, R1);
        end
        rd_req_a = 1'b0; rd_req_b = 1'b0;

        // Release together with a read; no write taken in the release cycle
        frame_release = 1'b1; rd_req_a = 1'b1; rd_addr_a = 32'd0; wr_req = 1'b1; wr_data = R2;
        #1;
        chk("rel_gnt_a", rd_gnt_a, 1);
        chk("rel_no_ack", wr_ack, 0);
        chk("rel_full", frame_full, 1);
        tick();
        rd_req_a = 1'b0;
        #1;
        chk("rel_full_clr", frame_full, 0);
        chk("rel_valid_a", rd_valid_a, 1);
        chk("rel_data_a", rd_data_a, R0);
        chk("refill0_ack", wr_ack, 1);
        chk("refill0_addr", mem_address, 0);
        tick();

        // Release in FILL is ignored; write beats an eligible read
        frame_release = 1'b0; wr_data = R3; rd_req_a = 1'b1; rd_addr_a = 32'd0;
        #1;
        chk("prio_ack", wr_ack, 1);
        chk("prio_addr", mem_address, 1);
        chk("prio_gnt_a", rd_gnt_a, 0);
        tick();
        wr_req = 1'b0;
        #1;
        chk("prio_full", frame_full, 1);
        chk("prio_gnt_a_late", rd_gnt_a, 1);
        chk("prio_addr_late", mem_address, 0);
        tick();
        rd_req_a = 1'b0;
        #1;
        chk("prio_valid_a", rd_valid_a, 1);
        chk("prio_data_a", rd_data_a, R2);

        // Reset mid-frame discards progress and suppresses the pending read
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0; wr_req = 1'b1; wr_data = R0;
        #1;
        chk("mid_ack", wr_ack, 1);
        tick();
        rd_req_b = 1'b1; rd_addr_b = 32'd0; rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", wr_ack, 0);
        chk("mid_rst_gnt_b", rd_gnt_b, 0);
        chk("mid_rst_we", mem_write_enable, 0);
        tick();
        rst_n = 1'b1; wr_req = 1'b0; rd_req_b = 1'b0;
        #1;
        chk("post_rst_valid_b", rd_valid_b, 0);
        chk("post_rst_err", rd_err, 0);
        chk("post_rst_data_a", rd_data_a, 0);
        chk("post_rst_data_b", rd_data_b, 0);
        chk("post_rst_full", frame_full, 0);
        wr_req = 1'b1; wr_data = R1;
        #1;
        chk("post_rst_ack", wr_ack, 1);
        chk("post_rst_addr", mem_address, 0);
        tick();
        wr_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
